// File: rtl/disp_pkg.sv
// Shared constants and helpers for the four-digit display scanner.
// Codes 14 and 15 are reserved by the downstream decoder for blank and minus.
package disp_pkg;

   localparam int unsigned NUM_DIGITS          = 4;
   localparam int unsigned DEFAULT_REFRESH_DIV = 100000;
   localparam logic [3:0]  BLANK_CODE          = 4'd14;
   localparam logic [3:0]  MINUS_CODE          = 4'd15;

   typedef logic [1:0]  digit_idx_t;
   typedef logic [15:0] digit_word_t;

   // Pick nibble k out of a packed four-digit word.
   function automatic logic [3:0] digit_of(
      input digit_word_t v,
      input digit_idx_t  k
   );
      return v[{k, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running dwell counter for the display scanner.
// Emits a one-cycle wrap strobe on the last cycle of each dwell period.
module scan_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic wrap_o
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Strobe on the terminal count and fold back to zero on the same edge.
   always_comb begin
      wrap_o = (cnt_q == LAST);
      cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed four-digit display scanner with frame-aligned double buffering.
// New digits are staged and only swapped in at the digit 3 -> 0 boundary.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits_in,
   input  logic        load,
   input  logic        blank_lz,
   output logic [1:0]  digit_sel,
   output logic [3:0]  num,
   output logic        pending,
   output logic        load_ack,
   output logic        frame_tick
);

   logic        wrap;
   logic        commit;
   digit_idx_t  idx_q,    idx_d;
   digit_word_t shadow_q, shadow_d;
   digit_word_t staged_q, staged_d;
   logic        pend_q,   pend_d;
   logic        ack_q,    ack_d;
   logic        tick_q,   tick_d;
   logic [NUM_DIGITS-1:0] lz;

   scan_prescaler #(
      .DIV (REFRESH_DIV)
   ) u_presc (
      .clk_i  (clk),
      .rst_i  (rst),
      .wrap_o (wrap)
   );

   // Advance the scan, stage loads, and swap buffers at the frame edge.
   always_comb begin
      commit   = wrap && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
      idx_d    = wrap ? idx_q + 2'd1 : idx_q;
      staged_d = load ? digits_in : staged_q;
      pend_d   = pend_q | load;
      shadow_d = shadow_q;
      ack_d    = 1'b0;
      tick_d   = commit;
      if (commit && pend_d) begin
         shadow_d = staged_d;
         pend_d   = 1'b0;
         ack_d    = 1'b1;
      end
   end

   // State registers; pulses are registered so they line up with digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         shadow_q <= '0;
         staged_q <= '0;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         staged_q <= staged_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         tick_q   <= tick_d;
      end
   end

   // A digit is a leading zero if it and every digit above it are zero.
   always_comb begin
      lz[3] = (shadow_q[15:12] == 4'd0);
      lz[2] = lz[3] && (shadow_q[11:8] == 4'd0);
      lz[1] = lz[2] && (shadow_q[7:4] == 4'd0);
      lz[0] = 1'b0;
   end

   // Present the active digit to the decoder.
   always_comb begin
      digit_sel  = idx_q;
      num        = digit_of(shadow_q, idx_q);
      if (blank_lz && lz[idx_q]) num = BLANK_CODE;
      pending    = pend_q;
      load_ack   = ack_q;
      frame_tick = tick_q;
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a four-cycle dwell.
// Expected outputs come from a time-based model of the scan and buffer rules.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits_in;
   logic        load;
   logic        blank_lz;
   logic [1:0]  digit_sel;
   logic [3:0]  num;
   logic        pending;
   logic        load_ack;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;

   int          m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_staged;
   bit          m_pending;
   bit          m_ack;

   display_scan_ctrl #(
      .REFRESH_DIV (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .digit_sel  (digit_sel),
      .num        (num),
      .pending    (pending),
      .load_ack   (load_ack),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic int e_idx();
      return (m_t / 4) % 4;
   endfunction

   function automatic logic [1:0] e_sel();
      return 2'(e_idx());
   endfunction

   function automatic bit e_tick();
      return (m_t > 0) && (m_t % 16 == 0);
   endfunction

   function automatic logic [3:0] e_num();
      logic [15:0] hi;
      hi = m_shadow >> (4 * e_idx());
      if (blank_lz && e_idx() > 0 && hi == 16'd0) return 4'd14;
      return hi[3:0];
   endfunction

   task automatic model_reset();
      m_t       = 0;
      m_shadow  = '0;
      m_staged  = '0;
      m_pending = 0;
      m_ack     = 0;
   endtask

   // One clock: apply inputs, advance the model, sample 1 time unit later.
   task automatic tick(input bit ld, input logic [15:0] din);
      load      = ld;
      digits_in = din;
      if (ld) begin
         m_staged  = din;
         m_pending = 1;
      end
      m_ack = 0;
      if (m_t % 16 == 15 && m_pending) begin
         m_shadow  = m_staged;
         m_pending = 0;
         m_ack     = 1;
      end
      @(posedge clk);
      m_t++;
      #1;
      load = 1'b0;
   endtask

   task automatic run_to_frame();
      for (int i = 0; i < 16 && (m_t % 16 != 0); i++) tick(0, 16'h0);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      load      = 1'b0;
      digits_in = '0;
      blank_lz  = 1'b0;
      #3;
      total++;
      if ({digit_sel, num, pending, load_ack, frame_tick} !== 9'd0) begin
         bad++;
         $display("FAIL reset got %b want 0",
                  {digit_sel, num, pending, load_ack, frame_tick});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      total++;
      if (digit_sel !== 2'd0 || num !== 4'd0) begin
         bad++;
         $display("FAIL release got sel=%0d num=%0d want 0 0", digit_sel, num);
      end
   endtask

   task automatic test_scan();
      int ticks = 0;
      for (int i = 0; i < 48; i++) begin
         tick(0, 16'h0);
         if (frame_tick) ticks++;
         total++;
         if ({digit_sel, frame_tick} !== {e_sel(), e_tick()}) begin
            bad++;
            $display("FAIL scan t=%0d got sel=%0d tick=%b want %0d %b",
                     m_t, digit_sel, frame_tick, e_sel(), e_tick());
         end
      end
      total++;
      if (ticks != 3) begin
         bad++;
         $display("FAIL scan_ticks got %0d want 3", ticks);
      end
   endtask

   task automatic test_load_commit();
      logic [3:0] seq [4];
      seq = '{4'd4, 4'd3, 4'd2, 4'd1};
      blank_lz = 1'b0;
      for (int i = 0; i < 16 && e_idx() != 1; i++) tick(0, 16'h0);
      tick(1, 16'h1234);
      while (m_t % 16 != 0) begin
         total++;
         if ({pending, num, load_ack} !== {1'b1, e_num(), 1'b0}) begin
            bad++;
            $display("FAIL staged t=%0d got p=%b num=%0d ack=%b want 1 %0d 0",
                     m_t, pending, num, load_ack, e_num());
         end
         tick(0, 16'h0);
      end
      total++;
      if ({load_ack, frame_tick, pending} !== 3'b110) begin
         bad++;
         $display("FAIL commit got ack=%b tick=%b p=%b want 1 1 0",
                  load_ack, frame_tick, pending);
      end
      for (int i = 0; i < 16; i++) begin
         if (m_t % 4 == 0) begin
            total++;
            if (num !== seq[e_idx()]) begin
               bad++;
               $display("FAIL seq digit=%0d got %0d want %0d",
                        e_idx(), num, seq[e_idx()]);
            end
         end
         tick(0, 16'h0);
      end
   endtask

   task automatic test_blank();
      logic [15:0] vals [3];
      logic [3:0]  tbl  [3][4];
      vals = '{16'h0050, 16'h0000, 16'hF001};
      tbl  = '{'{4'd0, 4'd5, 4'd14, 4'd14},
               '{4'd0, 4'd14, 4'd14, 4'd14},
               '{4'd1, 4'd0, 4'd0, 4'd15}};
      for (int v = 0; v < 3; v++) begin
         blank_lz = 1'b0;
         tick(1, vals[v]);
         run_to_frame();
         blank_lz = 1'b1;
         for (int i = 0; i < 16; i++) begin
            total++;
            if (num !== e_num() ||
                (m_t % 4 == 0 && num !== tbl[v][e_idx()])) begin
               bad++;
               $display("FAIL blank v=%h digit=%0d got %0d want %0d",
                        vals[v], e_idx(), num, e_num());
            end
            tick(0, 16'h0);
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] want [4];
      int acks = 0;
      want = '{4'd9, 4'd0, 4'd0, 4'd0};
      run_to_frame();
      tick(1, 16'hAAAA);
      tick(0, 16'h0);
      tick(0, 16'h0);
      tick(1, 16'h0009);
      for (int i = 0; i < 32; i++) begin
         if (load_ack) acks++;
         if (i >= 16 && m_t % 4 == 0) begin
            total++;
            if (num !== want[e_idx()]) begin
               bad++;
               $display("FAIL latest digit=%0d got %0d want %0d",
                        e_idx(), num, want[e_idx()]);
            end
         end
         tick(0, 16'h0);
      end
      total++;
      if (acks != 1) begin
         bad++;
         $display("FAIL b2b_acks got %0d want 1", acks);
      end
   endtask

   task automatic test_commit_cycle();
      int acks = 0;
      for (int i = 0; i < 16 && (m_t % 16 != 15); i++) tick(0, 16'h0);
      tick(1, 16'h5678);
      total++;
      if ({pending, load_ack, frame_tick, num} !== {3'b011, 4'd8}) begin
         bad++;
         $display("FAIL direct got p=%b ack=%b tick=%b num=%0d want 0 1 1 8",
                  pending, load_ack, frame_tick, num);
      end
      for (int i = 0; i < 16; i++) begin
         tick(0, 16'h0);
         if (load_ack) acks++;
         total++;
         if ({digit_sel, num, pending} !== {e_sel(), e_num(), 1'b0}) begin
            bad++;
            $display("FAIL direct_scan t=%0d got sel=%0d num=%0d p=%b",
                     m_t, digit_sel, num, pending);
         end
      end
      total++;
      if (acks != 0) begin
         bad++;
         $display("FAIL direct_acks got %0d want 0", acks);
      end
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      tick(0, 16'h0);
      tick(0, 16'h0);
      tick(1, 16'h4321);
      total++;
      if (pending !== 1'b1) begin
         bad++;
         $display("FAIL mid_pending got %b want 1", pending);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({digit_sel, num, pending} !== 7'd0) begin
         bad++;
         $display("FAIL async_rst got sel=%0d num=%0d p=%b want 0 0 0",
                  digit_sel, num, pending);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 24; i++) begin
         tick(0, 16'h0);
         if (load_ack) acks++;
         total++;
         if ({digit_sel, num, pending} !== {e_sel(), e_num(), 1'b0}) begin
            bad++;
            $display("FAIL post_rst t=%0d got sel=%0d num=%0d p=%b want %0d %0d 0",
                     m_t, digit_sel, num, pending, e_sel(), e_num());
         end
      end
      total++;
      if (acks != 0) begin
         bad++;
         $display("FAIL post_rst_acks got %0d want 0", acks);
      end
   endtask

   task automatic test_random();
      logic [15:0] din;
      logic [15:0] mask;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
         mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
         din  = 16'($urandom) & mask;
         tick($urandom_range(0, 9) == 0, din);
         total++;
         if ({digit_sel, num, pending, load_ack, frame_tick} !==
             {e_sel(), e_num(), m_pending, m_ack, e_tick()}) begin
            bad++;
            $display("FAIL rand t=%0d got %0d %0d %b %b %b want %0d %0d %b %b %b",
                     m_t, digit_sel, num, pending, load_ack, frame_tick,
                     e_sel(), e_num(), m_pending, m_ack, e_tick());
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_commit();
      test_blank();
      test_back_to_back();
      test_commit_cycle();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
